// File: rtl/uart_stream_bridge.sv
// UART <-> stream FIFO bridge: registered receive path with overflow drop counting, a
// completion-triggered transmit drain guarded by a send-done watchdog, and a compute enable.
module uart_stream_bridge #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned CNT_W      = 6,
  parameter int unsigned RCV_THRESH = 32,
  parameter int unsigned SND_THRESH = 32,
  parameter int unsigned AUTO_DRAIN = 0,
  parameter int unsigned TX_TIMEOUT = 200000
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [DATA_W-1:0] In_rx_data,
  input  logic              In_rx_data_vld,
  output logic [DATA_W-1:0] Out_tx_data,
  output logic              Out_tx_data_vld,
  input  logic              In_tx_send_done,
  input  logic [CNT_W-1:0]  In_rcv_wr_data_count,
  input  logic              In_rcv_full,
  output logic              Out_rcv_wr_en,
  output logic [DATA_W-1:0] Out_rcv_din,
  input  logic [CNT_W-1:0]  In_snd_rd_data_count,
  input  logic              In_snd_empty,
  output logic              Out_snd_rd_en,
  input  logic [DATA_W-1:0] In_snd_dout,
  input  logic              In_comp_done,
  output logic              Out_comp_enable,
  output logic [15:0]       Out_rx_drop_cnt,
  output logic              Out_tx_busy,
  output logic              Out_tx_timeout
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StWait = 2'd2;

  localparam int unsigned WaitW = (TX_TIMEOUT > 2) ? $clog2(TX_TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitLimit = WaitW'(TX_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RcvThresh = CNT_W'(RCV_THRESH);
  localparam logic [CNT_W-1:0] SndThresh = CNT_W'(SND_THRESH);
  localparam bit AutoDrain = (AUTO_DRAIN != 0);

  logic [1:0]       state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             done_d1_q, done_d2_q;
  logic             done_edge;
  logic             load;
  logic             timeout_set;
  logic             rx_accept;
  logic             rx_drop;

  assign done_edge = done_d1_q & ~done_d2_q;
  assign rx_accept = In_rx_data_vld & ~In_rcv_full;
  assign rx_drop   = In_rx_data_vld & In_rcv_full;

  // load marks the cycle whose edge pops the send FIFO and launches a byte
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    load        = 1'b0;
    timeout_set = 1'b0;
    case (state_q)
      StIdle: begin
        if (!In_snd_empty && (done_edge || AutoDrain)) begin
          state_d = StLoad;
          load    = 1'b1;
        end
      end
      StLoad: begin
        state_d    = StWait;
        wait_cnt_d = '0;
      end
      StWait: begin
        if (In_tx_send_done) begin
          if (!In_snd_empty) begin
            state_d = StLoad;
            load    = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else if (wait_cnt_q == WaitLimit) begin
          state_d     = StIdle;
          timeout_set = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q         <= StIdle;
      wait_cnt_q      <= '0;
      done_d1_q       <= 1'b0;
      done_d2_q       <= 1'b0;
      Out_snd_rd_en   <= 1'b0;
      Out_tx_data_vld <= 1'b0;
      Out_tx_data     <= '0;
      Out_tx_busy     <= 1'b0;
      Out_tx_timeout  <= 1'b0;
    end else begin
      state_q         <= state_d;
      wait_cnt_q      <= wait_cnt_d;
      done_d1_q       <= In_comp_done;
      done_d2_q       <= done_d1_q;
      Out_snd_rd_en   <= load;
      Out_tx_data_vld <= load;
      Out_tx_data     <= load ? In_snd_dout : '0;
      Out_tx_busy     <= (state_d != StIdle);
      if (timeout_set) begin
        Out_tx_timeout <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Out_rcv_wr_en   <= 1'b0;
      Out_rcv_din     <= '0;
      Out_rx_drop_cnt <= '0;
    end else begin
      Out_rcv_wr_en <= rx_accept;
      Out_rcv_din   <= rx_accept ? In_rx_data : '0;
      if (rx_drop && (Out_rx_drop_cnt != 16'hFFFF)) begin
        Out_rx_drop_cnt <= Out_rx_drop_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Out_comp_enable <= 1'b0;
    end else begin
      Out_comp_enable <= (In_rcv_wr_data_count > RcvThresh) &&
                         (In_snd_rd_data_count < SndThresh);
    end
  end

endmodule

// File: doc/uart_stream_bridge.md
UART_STREAM_BRIDGE -- requirements
Module: uart_stream_bridge

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_W, 8, byte width
- CNT_W, 6, FIFO count width
- RCV_THRESH, 32, receive-FIFO level that enables computation
- SND_THRESH, 32, send-FIFO level limit for computation
- AUTO_DRAIN, 0, 1 = transmit whenever the send FIFO is non-empty; 0 = transmit only after a completion edge
- TX_TIMEOUT, 200000, maximum cycles to wait for a send-done
REQ-002 Ports SHALL be (name, direction, width, meaning):
- Clk, in, 1, single clock
- Rst, in, 1, synchronous active-high reset
- In_rx_data, in, DATA_W, byte from the UART receiver
- In_rx_data_vld, in, 1, one-cycle strobe qualifying In_rx_data
- Out_tx_data, out, DATA_W, byte to the UART transmitter
- Out_tx_data_vld, out, 1, one-cycle transmit strobe
- In_tx_send_done, in, 1, transmitter finished its byte
- In_rcv_wr_data_count, in, CNT_W, receive-FIFO fill level
- In_rcv_full, in, 1, receive FIFO full
- Out_rcv_wr_en, out, 1, receive-FIFO write enable
- Out_rcv_din, out, DATA_W, receive-FIFO write data
- In_snd_rd_data_count, in, CNT_W, send-FIFO fill level
- In_snd_empty, in, 1, send FIFO empty
- Out_snd_rd_en, out, 1, send-FIFO read enable
- In_snd_dout, in, DATA_W, send-FIFO first-word-fall-through data
- In_comp_done, in, 1, computation-complete level
- Out_comp_enable, out, 1, computation enable
- Out_rx_drop_cnt, out, 16, bytes dropped because the receive FIFO was full
- Out_tx_busy, out, 1, transmit FSM not in IDLE
- Out_tx_timeout, out, 1, sticky watchdog flag

Function
REQ-003 All outputs SHALL be registered.
REQ-004 Receive path: when In_rx_data_vld=1 and In_rcv_full=0, the block SHALL drive Out_rcv_wr_en=1 and Out_rcv_din=In_rx_data on the next cycle (1-cycle latency). In every other case it SHALL drive Out_rcv_wr_en=0 and Out_rcv_din=0.
REQ-005 When In_rx_data_vld=1 and In_rcv_full=1, Out_rx_drop_cnt SHALL increment by 1 and saturate at 16'hFFFF, and the byte SHALL NOT be written.
REQ-006 The block SHALL register In_comp_done twice (d1, d2); done_edge = d1 & ~d2.
REQ-007 The transmit FSM SHALL have the states IDLE, LOAD and WAIT. Out_tx_busy SHALL be 1 in any state other than IDLE.
REQ-008 IDLE -> LOAD SHALL occur when In_snd_empty=0 and either (done_edge=1) or (AUTO_DRAIN=1). Otherwise the FSM SHALL stay in IDLE.
REQ-009 On entering LOAD, the block SHALL assert Out_snd_rd_en=1 and Out_tx_data_vld=1 for exactly one cycle, with Out_tx_data=In_snd_dout sampled at the transition. LOAD SHALL always go to WAIT.
REQ-010 WAIT behaviour:
- In_tx_send_done=1 and In_snd_empty=0 -> LOAD (back-to-back drain).
- In_tx_send_done=1 and In_snd_empty=1 -> IDLE.
REQ-011 Watchdog: a wait counter SHALL clear on entry to WAIT and increment every WAIT cycle. When it reaches TX_TIMEOUT-1 without a send-done, the FSM SHALL go to IDLE and set Out_tx_timeout=1, which stays set until Rst.
REQ-012 The block SHALL never assert Out_snd_rd_en while In_snd_empty=1.
REQ-013 A done_edge outside IDLE, or while the send FIFO is empty, SHALL be ignored and not queued.
REQ-014 In_tx_send_done outside WAIT SHALL be ignored.
REQ-015 Out_comp_enable SHALL be registered as 1 when In_rcv_wr_data_count > RCV_THRESH and In_snd_rd_data_count < SND_THRESH, and 0 otherwise. Comparisons SHALL be unsigned at CNT_W bits.
REQ-016 Receive, drop-count, transmit and enable logic SHALL operate independently in the same cycle; simultaneous events SHALL NOT block one another.

Reset
REQ-017 While Rst=1 at a clock edge, the following SHALL be 0: all outputs, d1, d2, the wait counter, Out_rx_drop_cnt and Out_tx_timeout. The FSM SHALL be forced to IDLE.
REQ-018 Rst asserted mid-drain SHALL abort the drain with no further read. After Rst deasserts, a new done_edge (or AUTO_DRAIN) SHALL be required to restart.

Verification
REQ-019 Rx 0xA5 vld with full=0 -> next cycle Out_rcv_wr_en=1, Out_rcv_din=0xA5. Three vld strobes with full=1 -> Out_rx_drop_cnt=3, no wr_en.
REQ-020 AUTO_DRAIN=0, send FIFO holding 3 bytes, In_comp_done rises at cycle c -> rd_en/tx_vld pulse at c+2. Each send-done yields the next pulse one cycle later. After the 3rd done, FSM returns to IDLE with exactly 3 rd_en pulses.
REQ-021 In_comp_done rises with the send FIFO empty -> no rd_en, no tx_vld, Out_tx_busy stays 0.
REQ-022 TX_TIMEOUT=16, no send-done after LOAD -> IDLE after 16 WAIT cycles, Out_tx_timeout=1.
REQ-023 rcv count=33, snd count=31 -> Out_comp_enable=1 next cycle. rcv=32 or snd=32 -> 0.
REQ-024 Rst pulsed during WAIT with Out_rx_drop_cnt=5 -> all outputs 0, FSM IDLE, no rd_en until the next done_edge.
